// File: rtl/game_phase_sequencer_if.sv
// Handshake bundle between the phase sequencer and the game-logic helper blocks.
// The sequencer raises one en_* at a time; each helper answers on its fin_* line.
interface game_phase_sequencer_if #(
  parameter int SCORE_W = 8
);
  logic               en_wall;
  logic               fin_wall;
  logic               collided;
  logic               en_player;
  logic               fin_player;
  logic               en_ghost;
  logic               fin_ghost;
  logic               en_gcoll;
  logic               fin_gcoll;
  logic               ghost_hit;
  logic               en_food;
  logic               fin_food;
  logic [SCORE_W-1:0] score;

  modport master (
    output en_wall, en_player, en_ghost, en_gcoll, en_food,
    input  fin_wall, collided, fin_player, fin_ghost, fin_gcoll, ghost_hit, fin_food, score
  );

  modport slave (
    input  en_wall, en_player, en_ghost, en_gcoll, en_food,
    output fin_wall, collided, fin_player, fin_ghost, fin_gcoll, ghost_hit, fin_food, score
  );
endinterface

// File: rtl/game_phase_sequencer.sv
// Per-tick scheduler: walks wall check, player move, ghost move, ghost collision and
// food in turn, latches win/lose, guards every phase with a watchdog and buffers one
// early tick so back-to-back steps run without a gap.
module game_phase_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8,
  parameter int WON_SCORE      = 188,
  parameter int SCORE_W        = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    tick,
  input  logic                    run,
  game_phase_sequencer_if.master  bus,
  output logic [2:0]              phase,
  output logic                    busy,
  output logic                    step_done,
  output logic [15:0]             step_count,
  output logic                    game_over,
  output logic                    you_won,
  output logic                    timeout_err,
  output logic                    tick_overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALL   = 3'd1,
    S_PLAYER = 3'd2,
    S_GHOST  = 3'd3,
    S_GCOLL  = 3'd4,
    S_FOOD   = 3'd5,
    S_CHECK  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          pending_q, pending_d;
  logic [15:0]   count_q, count_d;
  logic          over_q, over_d;
  logic          won_q, won_d;
  logic          tmo_q, tmo_d;
  logic          ovr_q, ovr_d;

  logic fin_s, in_phase_s, fin_ok_s, timeout_s, exit_s;
  logic collided_s, hit_s, win_s, done_s;

  // Decode the active phase's finish line; the first phase cycle ignores fin because
  // helpers may still hold a finished flag from their previous run.
  always_comb begin
    fin_s      = 1'b0;
    in_phase_s = 1'b1;
    case (state_q)
      S_WALL:   fin_s = bus.fin_wall;
      S_PLAYER: fin_s = bus.fin_player;
      S_GHOST:  fin_s = bus.fin_ghost;
      S_GCOLL:  fin_s = bus.fin_gcoll;
      S_FOOD:   fin_s = bus.fin_food;
      default:  in_phase_s = 1'b0;
    endcase
    fin_ok_s   = in_phase_s && fin_s && (wd_q != {TW{1'b0}});
    timeout_s  = in_phase_s && !fin_ok_s && (wd_q == TW'(TIMEOUT_CYCLES - 1));
    exit_s     = fin_ok_s || timeout_s;
    // A watchdog exit reports "no collision / no hit".
    collided_s = fin_ok_s && bus.collided;
    hit_s      = fin_ok_s && bus.ghost_hit;
    win_s      = (bus.score >= SCORE_W'(WON_SCORE));
    done_s     = (state_q == S_CHECK) && !win_s;
  end

  // State and watchdog registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wd_q    <= {TW{1'b0}};
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic; the watchdog restarts at every phase entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run && (tick || pending_q)) state_d = S_WALL; else state_d = S_IDLE;
      S_WALL:   if (exit_s) state_d = collided_s ? S_GHOST : S_PLAYER; else state_d = S_WALL;
      S_PLAYER: if (exit_s) state_d = S_GHOST; else state_d = S_PLAYER;
      S_GHOST:  if (exit_s) state_d = S_GCOLL; else state_d = S_GHOST;
      S_GCOLL:  if (exit_s) state_d = hit_s ? S_HALT : S_FOOD; else state_d = S_GCOLL;
      S_FOOD:   if (exit_s) state_d = S_CHECK; else state_d = S_FOOD;
      S_CHECK:  state_d = win_s ? S_HALT : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (in_phase_s && (state_d == state_q)) begin
      wd_d = wd_q + TW'(1);
    end else begin
      wd_d = {TW{1'b0}};
    end
  end

  // Pending tick slot, step counter and sticky status flags.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    over_d    = over_q || ((state_q == S_GCOLL) && hit_s);
    won_d     = won_q || ((state_q == S_CHECK) && win_s);
    tmo_d     = tmo_q || timeout_s;
    ovr_d     = ovr_q;
    if (state_q == S_HALT) begin
      pending_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      // With run high the slot is consumed (or stays empty); with run low ticks are ignored.
      pending_d = run ? 1'b0 : pending_q;
    end else if (tick) begin
      if (pending_q) begin
        ovr_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end
    if (done_s) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Status registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_q <= 1'b0;
      count_q   <= 16'd0;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      over_q    <= over_d;
      won_q     <= won_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  // Moore outputs decoded from the state register: one-hot enables and busy.
  always_comb begin
    bus.en_wall   = (state_q == S_WALL);
    bus.en_player = (state_q == S_PLAYER);
    bus.en_ghost  = (state_q == S_GHOST);
    bus.en_gcoll  = (state_q == S_GCOLL);
    bus.en_food   = (state_q == S_FOOD);
    busy          = (state_q != S_IDLE) && (state_q != S_HALT);
    phase         = state_q;
    step_done     = done_s;
    step_count    = count_q;
    game_over     = over_q;
    you_won       = won_q;
    timeout_err   = tmo_q;
    tick_overrun  = ovr_q;
  end

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed bench for game_phase_sequencer: each task drives one scenario and checks
// the cycle-by-cycle phase sequence against hand-written tables.
module tb_game_phase_sequencer;
  logic        clock = 1'b0;
  logic        resetn;
  logic        tick;
  logic        run;
  logic [2:0]  phase;
  logic        busy, step_done, game_over, you_won, timeout_err, tick_overrun;
  logic [15:0] step_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] ph_log [0:299];
  logic [4:0] en_log [0:299];
  logic       sd_log [0:299];

  game_phase_sequencer_if bus ();

  game_phase_sequencer dut (
    .clock       (clock),
    .resetn      (resetn),
    .tick        (tick),
    .run         (run),
    .bus         (bus),
    .phase       (phase),
    .busy        (busy),
    .step_done   (step_done),
    .step_count  (step_count),
    .game_over   (game_over),
    .you_won     (you_won),
    .timeout_err (timeout_err),
    .tick_overrun(tick_overrun)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] en_vec();
    return {bus.en_wall, bus.en_player, bus.en_ghost, bus.en_gcoll, bus.en_food};
  endfunction

  // Expected one-hot enable vector {wall,player,ghost,gcoll,food} for a phase code.
  function automatic logic [4:0] en_for(input int ph);
    case (ph)
      1: return 5'b10000;
      2: return 5'b01000;
      3: return 5'b00100;
      4: return 5'b00010;
      5: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    tick = 1'b0;
    run = 1'b1;
    bus.fin_wall = 1'b1; bus.fin_player = 1'b1; bus.fin_ghost = 1'b1;
    bus.fin_gcoll = 1'b1; bus.fin_food = 1'b1;
    bus.collided = 1'b0; bus.ghost_hit = 1'b0; bus.score = 8'd0;
    repeat (2) next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask

  // Tick in cycle 0 (plus optional extra ticks), then log cycles 1..n.
  task automatic run_tick(input int n, input int t2, input int t3);
    tick = 1'b1;
    for (int k = 1; k <= n; k++) begin
      next_cycle();
      ph_log[k] = phase;
      en_log[k] = en_vec();
      sd_log[k] = step_done;
      tick = ((k == t2) || (k == t3)) ? 1'b1 : 1'b0;
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick = 1'b0;
    run = 1'b0;
    bus.fin_wall = 1'b0; bus.fin_player = 1'b0; bus.fin_ghost = 1'b0;
    bus.fin_gcoll = 1'b0; bus.fin_food = 1'b0;
    bus.collided = 1'b0; bus.ghost_hit = 1'b0; bus.score = 8'd0;
    repeat (2) next_cycle();
    tests_run++;
    if ({phase, busy, step_done, step_count, game_over, you_won, timeout_err, tick_overrun, en_vec()} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset: phase=%0d busy=%b en=%b count=%0d expected all zero", phase, busy, en_vec(), step_count);
    end
    do_reset();
  endtask

  task automatic test_nominal();
    int exp_ph [1:12];
    exp_ph = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 0};
    run_tick(12, -1, -1);
    for (int k = 1; k <= 12; k++) begin
      tests_run++;
      if ({ph_log[k], en_log[k], sd_log[k]} !== {exp_ph[k][2:0], en_for(exp_ph[k]), (k == 11)}) begin
        tests_failed++;
        $display("FAIL nominal k=%0d: got ph=%0d en=%b sd=%b, expected ph=%0d en=%b sd=%b",
                 k, ph_log[k], en_log[k], sd_log[k], exp_ph[k], en_for(exp_ph[k]), (k == 11));
      end
    end
    tests_run++;
    if (step_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL nominal_count: got %0d expected 1", step_count);
    end
  endtask

  task automatic test_collided();
    int exp_ph [1:10];
    exp_ph = '{1, 1, 3, 3, 4, 4, 5, 5, 6, 0};
    bus.collided = 1'b1;
    run_tick(10, -1, -1);
    bus.collided = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tests_run++;
      if ({ph_log[k], en_log[k], sd_log[k]} !== {exp_ph[k][2:0], en_for(exp_ph[k]), (k == 9)}) begin
        tests_failed++;
        $display("FAIL collided k=%0d: got ph=%0d en=%b sd=%b, expected ph=%0d en=%b sd=%b",
                 k, ph_log[k], en_log[k], sd_log[k], exp_ph[k], en_for(exp_ph[k]), (k == 9));
      end
    end
    tests_run++;
    if (step_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL collided_count: got %0d expected 2", step_count);
    end
  endtask

  task automatic test_run_control();
    run = 1'b0;
    run_tick(4, -1, -1);
    run = 1'b1;
    repeat (3) next_cycle();
    tests_run++;
    if ({phase, busy} !== {3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL run_low_ignored: got phase=%0d busy=%b expected 0/0", phase, busy);
    end
    // Drop run mid-step: the step must still finish.
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    next_cycle();
    run = 1'b0;
    repeat (9) next_cycle();
    tests_run++;
    if ({phase, step_done} !== {3'd6, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_drop: got phase=%0d step_done=%b expected 6/1", phase, step_done);
    end
    next_cycle();
    next_cycle();
    tests_run++;
    if ({phase, step_count} !== {3'd0, 16'd3}) begin
      tests_failed++;
      $display("FAIL run_drop_idle: got phase=%0d count=%0d expected 0/3", phase, step_count);
    end
    run = 1'b1;
  endtask

  task automatic test_win();
    bus.score = 8'd187;
    run_tick(12, -1, -1);
    tests_run++;
    if ({ph_log[11], sd_log[11], ph_log[12], you_won, step_count} !== {3'd6, 1'b1, 3'd0, 1'b0, 16'd4}) begin
      tests_failed++;
      $display("FAIL score187: got ph11=%0d sd=%b ph12=%0d won=%b count=%0d expected 6/1/0/0/4",
               ph_log[11], sd_log[11], ph_log[12], you_won, step_count);
    end
    bus.score = 8'd188;
    run_tick(12, -1, -1);
    tests_run++;
    if ({ph_log[11], sd_log[11], ph_log[12], you_won, busy, step_count} !== {3'd6, 1'b0, 3'd7, 1'b1, 1'b0, 16'd4}) begin
      tests_failed++;
      $display("FAIL score188: got ph11=%0d sd=%b ph12=%0d won=%b busy=%b count=%0d expected 6/0/7/1/0/4",
               ph_log[11], sd_log[11], ph_log[12], you_won, busy, step_count);
    end
    do_reset();
  endtask

  task automatic test_ghost_hit();
    int exp_ph [1:12];
    logic [15:0] cnt;
    exp_ph = '{1, 1, 2, 2, 3, 3, 4, 4, 7, 7, 7, 7};
    bus.ghost_hit = 1'b1;
    bus.score = 8'd200;
    run_tick(12, -1, -1);
    for (int k = 1; k <= 12; k++) begin
      tests_run++;
      if ({ph_log[k], en_log[k], sd_log[k]} !== {exp_ph[k][2:0], en_for(exp_ph[k]), 1'b0}) begin
        tests_failed++;
        $display("FAIL ghost_hit k=%0d: got ph=%0d en=%b sd=%b, expected ph=%0d en=%b sd=0",
                 k, ph_log[k], en_log[k], sd_log[k], exp_ph[k], en_for(exp_ph[k]));
      end
    end
    tests_run++;
    if ({game_over, you_won} !== 2'b10) begin
      tests_failed++;
      $display("FAIL ghost_flags: got over=%b won=%b expected 1/0", game_over, you_won);
    end
    cnt = step_count;
    run_tick(12, -1, -1);
    tests_run++;
    if ({ph_log[3], en_log[3], ph_log[12], en_log[12], step_count} !== {3'd7, 5'd0, 3'd7, 5'd0, cnt}) begin
      tests_failed++;
      $display("FAIL halt_ignores_tick: got ph=%0d en=%b count=%0d expected 7/00000/%0d",
               ph_log[12], en_log[12], step_count, cnt);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int ghost_cycles = 0;
    int done_cycles = 0;
    bus.fin_ghost = 1'b0;
    run_tick(270, -1, -1);
    bus.fin_ghost = 1'b1;
    for (int k = 1; k <= 270; k++) begin
      ghost_cycles += int'(en_log[k][2]);
      done_cycles  += int'(sd_log[k]);
    end
    tests_run++;
    if (ghost_cycles !== 255) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d ghost cycles expected 255", ghost_cycles);
    end
    tests_run++;
    if ({ph_log[259], ph_log[260], en_log[260], sd_log[264], ph_log[265]} !== {3'd3, 3'd4, 5'b00010, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL timeout_exit: got ph259=%0d ph260=%0d en260=%b sd264=%b ph265=%0d expected 3/4/00010/1/0",
               ph_log[259], ph_log[260], en_log[260], sd_log[264], ph_log[265]);
    end
    tests_run++;
    if ({timeout_err, done_cycles} !== {1'b1, 32'd1}) begin
      tests_failed++;
      $display("FAIL timeout_flag: got err=%b done=%0d expected 1/1", timeout_err, done_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ph [1:12];
    exp_ph = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 0};
    do_reset();
    run_tick(24, 4, -1);
    for (int k = 1; k <= 24; k++) begin
      tests_run++;
      if (ph_log[k] !== exp_ph[(k - 1) % 12 + 1][2:0]) begin
        tests_failed++;
        $display("FAIL back_to_back k=%0d: got ph=%0d expected %0d", k, ph_log[k], exp_ph[(k - 1) % 12 + 1]);
      end
    end
    tests_run++;
    if ({step_count, tick_overrun} !== {16'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL back_to_back_count: got count=%0d ovr=%b expected 2/0", step_count, tick_overrun);
    end
  endtask

  task automatic test_overrun_async_reset();
    do_reset();
    run_tick(7, 4, 6);
    tests_run++;
    if ({tick_overrun, phase, en_vec()} !== {1'b1, 3'd4, 5'b00010}) begin
      tests_failed++;
      $display("FAIL overrun: got ovr=%b phase=%0d en=%b expected 1/4/00010", tick_overrun, phase, en_vec());
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({phase, busy, step_done, step_count, game_over, you_won, timeout_err, tick_overrun, en_vec()} !== 30'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got phase=%0d busy=%b en=%b ovr=%b expected all zero",
               phase, busy, en_vec(), tick_overrun);
    end
    next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_collided();
    test_run_control();
    test_win();
    test_ghost_hit();
    test_timeout();
    test_back_to_back();
    test_overrun_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
